// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator: channel states, mode
// encodings and the default-divisor helper.
package clk_en_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // All-ones divisor of the given width: the slowest period, 2^cnt_w cycles.
    function automatic logic [31:0] def_div(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/clock_enable_ch.sv
// One clock-enable channel: counter, active/shadow divisor and mode,
// pending flag, registered tick and divided square wave.
module clock_enable_ch
    import clk_en_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(def_div(CNT_W))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             clk_out,
    output logic             running,
    output logic             pending
);

    ch_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_div, act_div_nxt, shd_div, shd_div_nxt;
    logic             act_mode, act_mode_nxt, shd_mode, shd_mode_nxt;
    logic             pend_nxt, tick_nxt, clk_out_nxt;
    logic             term;

    // State and datapath registers; reset puts the channel idle on DEF_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            act_div  <= DEF_DIV;
            act_mode <= MODE_PERIODIC;
            shd_div  <= DEF_DIV;
            shd_mode <= MODE_PERIODIC;
            pending  <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            act_div  <= act_div_nxt;
            act_mode <= act_mode_nxt;
            shd_div  <= shd_div_nxt;
            shd_mode <= shd_mode_nxt;
            pending  <= pend_nxt;
            tick     <= tick_nxt;
            clk_out  <= clk_out_nxt;
        end
    end

    // Next state: stop beats start, start beats terminal count, then config.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        act_div_nxt  = act_div;
        act_mode_nxt = act_mode;
        shd_div_nxt  = shd_div;
        shd_mode_nxt = shd_mode;
        pend_nxt     = pending;
        tick_nxt     = 1'b0;
        clk_out_nxt  = clk_out;
        term         = (state == ST_RUN) && (cnt == act_div);

        if (stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else if (start) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else if (term) begin
            cnt_nxt     = '0;
            tick_nxt    = 1'b1;
            clk_out_nxt = ~clk_out;
            if (act_mode == MODE_ONESHOT)
                state_nxt = ST_IDLE;
        end else if (state == ST_RUN) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        // A pending divisor only takes over at a period boundary.
        if (pending && (stop || start || term)) begin
            act_div_nxt  = shd_div;
            act_mode_nxt = shd_mode;
            pend_nxt     = 1'b0;
        end

        // Idle channels (or ones going idle now) take the write directly;
        // running ones park it in the shadow so no period is cut short.
        if (cfg_we) begin
            if (state == ST_IDLE || state_nxt == ST_IDLE) begin
                act_div_nxt  = cfg_div;
                act_mode_nxt = cfg_oneshot;
            end else begin
                shd_div_nxt  = cfg_div;
                shd_mode_nxt = cfg_oneshot;
                pend_nxt     = 1'b1;
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: config channel decode and ready mux
// in front of an array of independent channels.
module clock_enable_gen
    import clk_en_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter int               NUM_CH  = 2,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(def_div(CNT_W)),
    localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] running
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_we;

    // Ready follows the addressed channel; out-of-range indices always accept.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch == CH_W'(i))
                cfg_ready = !pending[i];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cfg_we[i] = cfg_valid && !pending[i] && (cfg_ch == CH_W'(i));

        clock_enable_ch #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[i]),
            .stop       (stop[i]),
            .cfg_we     (cfg_we[i]),
            .cfg_div    (cfg_div),
            .cfg_oneshot(cfg_oneshot),
            .tick       (tick[i]),
            .clk_out    (clk_out[i]),
            .running    (running[i]),
            .pending    (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: expected tick cycles are queued when
// stimulus is driven and compared with ticks logged by a negedge monitor.
module tb_clock_enable_gen;

    localparam int CNT_W  = 4;
    localparam int NUM_CH = 3;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] start, stop;
    logic              cfg_valid, cfg_ready, cfg_oneshot;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick, clk_out, running;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int obs_q[$];
    int exp_q[$];
    int obs_rd = 0;
    logic [NUM_CH-1:0] exp_clk = '0;

    clock_enable_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
        .tick(tick), .clk_out(clk_out), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every tick as cycle*16+channel, sampled mid-cycle.
    always @(negedge clk)
        for (int c = 0; c < NUM_CH; c++)
            if (tick[c] === 1'b1) obs_q.push_back(cyc * 16 + c);

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse start/stop for one cycle; e is the edge index that samples it.
    task automatic drive_start(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] p, output int e);
        @(negedge clk);
        start = s; stop = p;
        e = cyc + 1;
        @(negedge clk);
        start = '0; stop = '0;
    endtask

    task automatic drive_stop_at(input int s, input logic [NUM_CH-1:0] p);
        wait_until(s);
        stop = p;
        @(negedge clk);
        stop = '0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] div, input logic os);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = div; cfg_oneshot = os;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Queue the ticks of a periodic run started at edge e, stopped after cycle s.
    task automatic expect_periodic(input int ch, input int e, input int div, input int s);
        for (int t = e + div + 1; t <= s; t += div + 1) begin
            exp_q.push_back(t * 16 + ch);
            exp_clk[ch] = ~exp_clk[ch];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = '0; stop = '0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0; cfg_oneshot = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if (tick !== 3'b000 || clk_out !== 3'b000 || running !== 3'b000)
            $display("FAIL reset_outputs: tick=%b clk_out=%b running=%b expected all 0", tick, clk_out, running);
        else n_pass++;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_default_div;
        int e, o, x;
        drive_start(3'b001, 3'b000, e);
        expect_periodic(0, e, 15, e + 50);
        drive_stop_at(e + 50, 3'b001);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL default_div count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL default_div tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
        n_chk++;
        if (clk_out !== exp_clk || running !== 3'b000)
            $display("FAIL default_div state: clk_out=%b running=%b expected %b/000", clk_out, running, exp_clk);
        else n_pass++;
    endtask

    task automatic test_div;
        int e, o, x;
        logic base;
        cfg_write(2'd0, 4'd3, 1'b0);
        drive_start(3'b001, 3'b000, e);
        expect_periodic(0, e, 3, e + 13);
        drive_stop_at(e + 13, 3'b001);
        cfg_write(2'd0, 4'd0, 1'b0);
        drive_start(3'b001, 3'b000, e);
        base = exp_clk[0];
        expect_periodic(0, e, 0, e + 6);
        for (int k = 1; k <= 4; k++) begin
            wait_until(e + k);
            n_chk++;
            if (clk_out[0] !== (base ^ k[0]))
                $display("FAIL div0_clk_out: cyc %0d got %b expected %b", cyc, clk_out[0], base ^ k[0]);
            else n_pass++;
        end
        drive_stop_at(e + 6, 3'b001);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL div count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL div tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
        n_chk++;
        if (clk_out !== exp_clk) $display("FAIL div clk_out: got %b expected %b", clk_out, exp_clk);
        else n_pass++;
    endtask

    task automatic test_shadow;
        int e, o, x;
        cfg_write(2'd0, 4'd5, 1'b0);
        drive_start(3'b001, 3'b000, e);
        wait_until(e + 2);
        cfg_ch = 2'd0;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL shadow ready_before: got %b expected 1", cfg_ready);
        else n_pass++;
        cfg_valid = 1'b1; cfg_div = 4'd2; cfg_oneshot = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        n_chk++;
        if (cfg_ready !== 1'b0) $display("FAIL shadow ready_pending: got %b expected 0", cfg_ready);
        else n_pass++;
        cfg_ch = 2'd1;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL shadow ready_other_ch: got %b expected 1", cfg_ready);
        else n_pass++;
        cfg_ch = 2'd0;
        wait_until(e + 5);
        n_chk++;
        if (cfg_ready !== 1'b0) $display("FAIL shadow ready_before_tc: got %b expected 0", cfg_ready);
        else n_pass++;
        wait_until(e + 6);
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL shadow ready_after_tc: got %b expected 1", cfg_ready);
        else n_pass++;
        for (int t = e + 6; t <= e + 15; t += 3) begin
            exp_q.push_back(t * 16);
            exp_clk[0] = ~exp_clk[0];
        end
        drive_stop_at(e + 16, 3'b001);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL shadow count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL shadow tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_oneshot;
        int e, e2, o, x;
        cfg_write(2'd1, 4'd4, 1'b1);
        drive_start(3'b010, 3'b000, e);
        wait_until(e + 4);
        n_chk++;
        if (running[1] !== 1'b1) $display("FAIL oneshot running_before: got %b expected 1", running[1]);
        else n_pass++;
        wait_until(e + 5);
        n_chk++;
        if (running[1] !== 1'b0 || tick[1] !== 1'b1)
            $display("FAIL oneshot tick_cycle: running=%b tick=%b expected 0/1", running[1], tick[1]);
        else n_pass++;
        exp_q.push_back((e + 5) * 16 + 1);
        exp_clk[1] = ~exp_clk[1];
        wait_until(e + 8);
        drive_start(3'b010, 3'b000, e2);
        exp_q.push_back((e2 + 5) * 16 + 1);
        exp_clk[1] = ~exp_clk[1];
        wait_until(e2 + 14);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL oneshot count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL oneshot tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
        n_chk++;
        if (running !== 3'b000 || clk_out !== exp_clk)
            $display("FAIL oneshot end: running=%b clk_out=%b expected 000/%b", running, clk_out, exp_clk);
        else n_pass++;
    endtask

    task automatic test_start_stop;
        int e, o, x;
        cfg_write(2'd0, 4'd3, 1'b0);
        drive_start(3'b001, 3'b001, e);
        n_chk++;
        if (running[0] !== 1'b0) $display("FAIL start_stop running: got %b expected 0", running[0]);
        else n_pass++;
        wait_until(e + 8);
        drive_start(3'b001, 3'b000, e);
        wait_until(e + 3);
        start = 3'b001;
        @(negedge clk);
        start = '0;
        exp_q.push_back((e + 8) * 16);
        exp_q.push_back((e + 12) * 16);
        drive_stop_at(e + 13, 3'b001);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL start_stop count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL start_stop tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_mid;
        int e, o, x;
        cfg_write(2'd0, 4'd5, 1'b0);
        drive_start(3'b001, 3'b000, e);
        wait_until(e + 2);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 4'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_until(e + 6);
        exp_q.push_back((e + 6) * 16);
        #2 rst_n = 1'b0;
        #1;
        exp_clk = '0;
        n_chk++;
        if (tick !== 3'b000 || clk_out !== 3'b000 || running !== 3'b000)
            $display("FAIL reset_mid outputs: tick=%b clk_out=%b running=%b expected all 0", tick, clk_out, running);
        else n_pass++;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_mid ready: got %b expected 1", cfg_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 4'd0; cfg_oneshot = 1'b0;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) $display("FAIL bad_ch ready: got %b expected 1", cfg_ready);
        else n_pass++;
        @(negedge clk);
        cfg_valid = 1'b0; cfg_ch = 2'd0;
        drive_start(3'b011, 3'b000, e);
        exp_q.push_back((e + 16) * 16);
        exp_q.push_back((e + 16) * 16 + 1);
        exp_clk = 3'b011;
        drive_stop_at(e + 17, 3'b011);
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_q.size() - obs_rd !== exp_q.size())
            $display("FAIL reset_mid count: got %0d ticks expected %0d", obs_q.size() - obs_rd, exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            o = (obs_rd < obs_q.size()) ? obs_q[obs_rd] : -1;
            obs_rd++;
            n_chk++;
            if (o !== x) $display("FAIL reset_mid tick: got cyc %0d ch %0d expected cyc %0d ch %0d", o / 16, o % 16, x / 16, x % 16);
            else n_pass++;
        end
        obs_rd = obs_q.size();
        n_chk++;
        if (clk_out !== exp_clk) $display("FAIL reset_mid clk_out: got %b expected %b", clk_out, exp_clk);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_div();
        test_shadow();
        test_oneshot();
        test_start_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
